// File: rtl/snn_cfg_pkg.sv
// Shared types and constants for the SNN configuration loader.
package snn_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_CHECK,
    ST_COMMIT,
    ST_DONE
  } state_e;

  localparam int          NUM_PARAMS_DEF  = 15;
  localparam logic [7:0]  HEADER_DEF      = 8'hA5;
  localparam int          TIMEOUT_CYC_DEF = 255;

  // Fixed network register map; second-layer weights are 3x3 row-major from base.
  localparam logic [3:0] ADDR_THRESHOLD = 4'd0;
  localparam logic [3:0] ADDR_LEAK      = 4'd1;
  localparam logic [3:0] ADDR_REFRAC    = 4'd2;
  localparam logic [3:0] ADDR_W1_BASE   = 4'd3;
  localparam logic [3:0] ADDR_W2_BASE   = 4'd6;

endpackage

// File: rtl/snn_cfg_loader.sv
// Buffers one checksummed parameter frame from a byte stream, then commits it
// into the network register file one write per cycle while holding spikes off.
module snn_cfg_loader
  import snn_cfg_pkg::*;
#(
  parameter int         NUM_PARAMS  = NUM_PARAMS_DEF,
  parameter logic [7:0] HEADER      = HEADER_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [3:0] cfg_addr,
  output logic [7:0] cfg_data,
  output logic       cfg_we,
  output logic       net_hold,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [3:0]       IDX_LAST = 4'(NUM_PARAMS - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       sum_q, sum_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             error_q, error_d;
  logic [7:0]       buf_q [NUM_PARAMS];
  logic [7:0]       buf_d [NUM_PARAMS];
  logic             xfer;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      sum_q   <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
    end
  end

  // Payload storage needs no reset; it is always overwritten before commit.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    tmo_d   = tmo_q;
    error_d = error_q;
    buf_d   = buf_q;
    case (state_q)
      ST_IDLE: begin
        if (xfer && in_data == HEADER) begin
          state_d = ST_RECV;
          error_d = 1'b0;
          idx_d   = '0;
          sum_d   = '0;
          tmo_d   = '0;
        end
      end
      ST_RECV, ST_CHECK: begin
        if (xfer) begin
          tmo_d = '0;
          if (state_q == ST_RECV) begin
            buf_d[idx_q] = in_data;
            sum_d        = sum_q + in_data;
            idx_d        = idx_q + 4'd1;
            if (idx_q == IDX_LAST) state_d = ST_CHECK;
          end else if (in_data == sum_q) begin
            state_d = ST_COMMIT;
            idx_d   = '0;
          end else begin
            state_d = ST_IDLE;
            error_d = 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // This idle cycle is the TIMEOUT_CYC-th in a row: abandon the frame.
          state_d = ST_IDLE;
          error_d = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        idx_d = idx_q + 4'd1;
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs decode registered state only, so nothing from in_* reaches cfg_*.
  always_comb begin
    in_ready = (state_q == ST_IDLE) || (state_q == ST_RECV) || (state_q == ST_CHECK);
    cfg_we   = (state_q == ST_COMMIT);
    net_hold = (state_q == ST_COMMIT);
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    error    = error_q;
    cfg_addr = '0;
    cfg_data = '0;
    if (state_q == ST_COMMIT) begin
      cfg_addr = idx_q;
      cfg_data = buf_q[idx_q];
    end
  end

endmodule

// File: tb/tb_snn_cfg_loader.sv
// Directed bench for snn_cfg_loader: frames, bad checksum, junk, timeout, reset mid-commit.
module tb_snn_cfg_loader;
  import snn_cfg_pkg::*;

  logic       clk, rst_n, in_valid, in_ready, cfg_we, net_hold, busy, done, error;
  logic [7:0] in_data, cfg_data;
  logic [3:0] cfg_addr;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int wcnt = 0, dcnt = 0, herr = 0, dcyc = 0;
  logic [3:0] waddr [512];
  logic [7:0] wdata [512];
  int         wcyc  [512];

  snn_cfg_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_we(cfg_we),
    .net_hold(net_hold), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cfg_we && wcnt < 512) begin
        waddr[wcnt] = cfg_addr;
        wdata[wcnt] = cfg_data;
        wcyc[wcnt]  = cyc;
        wcnt++;
      end
      if (done) begin
        dcnt++;
        dcyc = cyc;
      end
      if (net_hold != cfg_we) herr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] p [15], input logic [7:0] cs);
    send_byte(8'hA5);
    for (int i = 0; i < 15; i++) send_byte(p[i]);
    send_byte(cs);
  endtask

  // Verifies the 15 writes starting at monitor index w0, their contiguity and the done pulse.
  task automatic check_commit(input string tag, input int w0, input int d0, input logic [7:0] p [15]);
    int bad_a, bad_d;
    bad_a = 0;
    bad_d = 0;
    chk({tag, "_wcnt"}, wcnt - w0, 15);
    if (wcnt - w0 == 15) begin
      for (int i = 0; i < 15; i++) begin
        if (waddr[w0+i] != 4'(i)) bad_a++;
        if (wdata[w0+i] != p[i]) bad_d++;
      end
      chk({tag, "_addr_seq"}, bad_a, 0);
      chk({tag, "_data_seq"}, bad_d, 0);
      chk({tag, "_contig"}, wcyc[w0+14] - wcyc[w0], 14);
      chk({tag, "_done_cyc"}, dcyc - wcyc[w0+14], 1);
    end
    chk({tag, "_done_cnt"}, dcnt - d0, 1);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  logic [7:0] pay [15];
  logic [7:0] pay2 [15];
  int w0, d0, found;

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    rst_n    = 1'b0;
    for (int i = 0; i < 15; i++) pay[i] = 8'h10 + 8'(i);
    pay2 = pay;
    pay2[5] = 8'hA5;
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(10);
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_we", cfg_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    chk("rst_hold", net_hold, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", cfg_addr, 0);
    chk("rst_data", cfg_data, 0);

    // Good frame: checksum of 10..1E is 0x159 -> 0x59.
    w0 = wcnt; d0 = dcnt;
    send_frame(pay, 8'h59);
    #1 chk("good_we_after_cs", cfg_we, 1);
    chk("good_ready_commit", in_ready, 0);
    idle(20);
    check_commit("good", w0, d0, pay);
    chk("good_error", error, 0);

    // Bad checksum: no writes, sticky error.
    w0 = wcnt; d0 = dcnt;
    send_frame(pay, 8'h58);
    idle(20);
    #1;
    chk("bad_wcnt", wcnt - w0, 0);
    chk("bad_error", error, 1);
    chk("bad_busy", busy, 0);
    chk("bad_done", dcnt - d0, 0);

    // Next header clears error; frame commits normally.
    w0 = wcnt; d0 = dcnt;
    send_byte(8'hA5);
    chk("hdr_clears_error", error, 0);
    for (int i = 0; i < 15; i++) send_byte(pay[i]);
    send_byte(8'h59);
    idle(20);
    check_commit("recover", w0, d0, pay);

    // Junk in IDLE ignored; A5 inside the payload is data (sum 0x59-0x15+0xA5 = 0xE9).
    w0 = wcnt; d0 = dcnt;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    #1 chk("junk_busy", busy, 0);
    send_frame(pay2, 8'hE9);
    idle(20);
    check_commit("a5data", w0, d0, pay2);

    // 254 idle cycles inside RECV: still within budget.
    w0 = wcnt; d0 = dcnt;
    send_byte(8'hA5);
    for (int i = 0; i < 7; i++) send_byte(pay[i]);
    idle(254);
    #1 chk("gap254_busy", busy, 1);
    for (int i = 7; i < 15; i++) send_byte(pay[i]);
    send_byte(8'h59);
    idle(20);
    check_commit("gap254", w0, d0, pay);
    chk("gap254_error", error, 0);

    // 255 idle cycles: aborts to IDLE with error.
    w0 = wcnt; d0 = dcnt;
    send_byte(8'hA5);
    for (int i = 0; i < 7; i++) send_byte(pay[i]);
    idle(254);
    #1 chk("gap255_pre_busy", busy, 1);
    idle(1);
    #1;
    chk("gap255_busy", busy, 0);
    chk("gap255_error", error, 1);
    for (int i = 7; i < 15; i++) send_byte(pay[i]);
    send_byte(8'h59);
    idle(20);
    chk("gap255_wcnt", wcnt - w0, 0);
    chk("gap255_done", dcnt - d0, 0);

    // Reset mid-commit at address 5.
    send_frame(pay, 8'h59);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge clk);
      if (cfg_we && cfg_addr == 4'd5) found = 1;
    end
    chk("rstmid_reach_addr5", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstmid_we_async", cfg_we, 0);
    chk("rstmid_hold_async", net_hold, 0);
    @(negedge clk) rst_n = 1'b1;
    w0 = wcnt;
    idle(30);
    #1;
    chk("rstmid_ready", in_ready, 1);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_no_writes", wcnt - w0, 0);

    chk("hold_tracks_we", herr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
